// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   mult_state_t : controller state encoding
//   cnt_width()  : bits needed to count 0..width partial-product steps
package seq_mult_pkg;

   typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t;

   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/mult_sign_unit.sv
// Combinational sign handling for seq_multiplier.
//   a, b       : raw operands
//   is_signed  : operands are two's complement
//   mag_a/b    : unsigned magnitudes (raw operands in unsigned mode)
//   value      : unsigned 2*WIDTH-bit product magnitude
//   negate     : apply two's-complement negation to value
//   result     : signed-corrected product
module mult_sign_unit
   import seq_mult_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               is_signed,
   output logic [WIDTH-1:0]   mag_a,
   output logic [WIDTH-1:0]   mag_b,
   input  logic [2*WIDTH-1:0] value,
   input  logic               negate,
   output logic [2*WIDTH-1:0] result
);

   // -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
   assign mag_a  = (is_signed && a[WIDTH-1]) ? -a : a;
   assign mag_b  = (is_signed && b[WIDTH-1]) ? -b : b;
   assign result = negate ? -value : value;

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, one partial product per clock, full 2*WIDTH-bit result.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, b, is_signed sampled on acceptance)
//   out_valid / out_ready: product handshake
//   product              : result, held until the next completion
//   busy                 : operation in CALC or DONE
module seq_multiplier
   import seq_mult_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               is_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam int unsigned CntW = cnt_width(WIDTH);
   localparam int unsigned PW   = 2 * WIDTH;

   mult_state_t       state_q, state_d;
   logic [PW:0]       acc_q, acc_d;
   logic [WIDTH-1:0]  mcand_q, mcand_d;
   logic [WIDTH-1:0]  mplier_q, mplier_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              neg_q, neg_d;
   logic [PW-1:0]     product_q, product_d;

   logic [WIDTH-1:0]  mag_a, mag_b;
   logic [PW-1:0]     signed_res;
   logic [WIDTH:0]    upper_sum;
   logic [PW:0]       acc_step;
   logic              last_step;
   logic              accept;
   logic              unused_acc_lsb;

   mult_sign_unit #(
      .WIDTH (WIDTH)
   ) u_sign (
      .a         (a),
      .b         (b),
      .is_signed (is_signed),
      .mag_a     (mag_a),
      .mag_b     (mag_b),
      .value     (acc_step[PW-1:0]),
      .negate    (neg_q),
      .result    (signed_res)
   );

   // One shift-add step: add multiplicand into the upper half, then shift right.
   assign upper_sum = acc_q[PW:WIDTH] + (mplier_q[0] ? {1'b0, mcand_q} : '0);
   assign acc_step  = {1'b0, upper_sum, acc_q[WIDTH-1:1]};
   assign last_step = (cnt_q == CntW'(WIDTH - 1));
   assign accept    = in_valid && (state_q == IDLE);
   // Bit 0 is always shifted out before the product is taken.
   assign unused_acc_lsb = acc_q[0];

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid) state_d = CALC;
         CALC:    if (last_step) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      busy      = (state_q == CALC) || (state_q == DONE);
      product   = product_q;
   end

   // Datapath next-state
   always_comb begin
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      product_d = product_q;
      if (accept) begin
         acc_d    = '0;
         mcand_d  = mag_a;
         mplier_d = mag_b;
         cnt_d    = '0;
         neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      end else if (state_q == CALC) begin
         acc_d    = acc_step;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CntW'(1);
         if (last_step) product_d = signed_res;
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         product_q <= '0;
      end else begin
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         cnt_q     <= cnt_d;
         neg_q     <= neg_d;
         product_q <= product_d;
      end
   end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised, iterative shift-add multiplier producing the full 2*WIDTH-bit product.
- Performs one partial-product step per clock, replacing the wide combinational adder tree in area-constrained datapaths.
- Supports signed or unsigned mode per transaction.
- Uses a valid/ready handshake on both input and output, so it drops into pipelined datapaths with backpressure.

Parameters:
- WIDTH, 8, operand width in bits (>= 2); product width is 2*WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands and mode valid.
- in_ready  output  1  block can accept a new operation.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- is_signed  input  1  1 = operands are two's complement; 0 = unsigned.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  result, two's complement when is_signed was set.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset: one clock; reset is synchronous and active-low. When rst_n is low at a rising clk edge:
  - state goes to IDLE;
  - in_ready=1 after the edge; out_valid=0, busy=0, product=0;
  - internal accumulator, operand and counter registers are cleared.
- Reset takes priority over every other event, including mid-CALC and mid-DONE. An in-flight operation is discarded with no out_valid pulse.
- States:
  - IDLE: in_ready=1. When in_valid&&in_ready at edge k:
    - latch |a| and |b| as WIDTH-bit unsigned magnitudes (the magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and fits);
    - latch neg = is_signed & (a[MSB]^b[MSB]);
    - clear the accumulator and counter; go to CALC.
    - In unsigned mode the magnitudes are the raw operands.
  - CALC: in_ready=0. On each edge:
    - if the multiplier LSB is 1, add the multiplicand to the upper half of the 2*WIDTH+1-bit accumulator;
    - shift the accumulator right by 1 and the multiplier right by 1; increment the counter.
    - The final step happens at edge k+WIDTH. At that edge the sign correction (two's-complement negate if neg) is applied, product is registered and the state goes to DONE.
  - DONE: out_valid=1, product stable, in_ready=0. When out_valid&&out_ready, go to IDLE at that edge: out_valid=0 and in_ready=1 after the edge.
- Latency: out_valid rises after edge k+WIDTH, i.e. exactly WIDTH cycles after acceptance. The latency is fixed and independent of operand values (no early termination).
- Throughput: one operation per WIDTH+2 cycles minimum. There is no acceptance in the same cycle as output retirement.
- Holding rules:
  - product holds its value after retirement until the next completion; only out_valid qualifies it.
  - in_valid while busy is ignored and does not stall or corrupt the operation.
  - Operand inputs are sampled only at the acceptance edge; later changes have no effect.
- out_ready low in DONE holds out_valid and product indefinitely.
- Arithmetic: the result is exact for all operand pairs; no overflow is possible in 2*WIDTH bits.
  - Signed range: (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2) fits.
  - Unsigned range: (2^WIDTH-1)^2 fits.

Decomposition:
- Shared package seq_mult_pkg holds:
  - typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t;
  - the counter width function clog2(WIDTH+1).
- One natural sub-module, mult_sign_unit (combinational, parametrised by WIDTH), used at acceptance and completion:
  - operand magnitude extraction;
  - conditional two's-complement negation of a 2*WIDTH-bit value.

Test Plan (WIDTH=8 unless stated):
- Unsigned max: a=0xFF, b=0xFF, is_signed=0 -> out_valid exactly 8 cycles after accept, product=0xFE01; in_ready low throughout.
- Signed mixed: a=0xFD (-3), b=0x05, is_signed=1 -> product=0xFFF1 (-15). Then a=0x80, b=0x80 signed -> product=0x4000.
- Zero and identity: a=0x00, b=0xA7 -> product=0x0000. Then a=0x01, b=0xA7, signed -> product=0xFFA7.
- Backpressure: out_ready held low 20 cycles after completion of 0x12*0x34 -> out_valid and product=0x03A8 stable all 20 cycles. in_valid pulses during the hold are ignored. Raising out_ready retires and in_ready=1 the next cycle.
- Reset mid-operation: rst_n low at the 4th CALC cycle -> after the edge in_ready=1, out_valid=0, busy=0, product=0. A following 0x0A*0x0B -> 0x006E with normal latency.
- Randomised sweep at WIDTH=16 and WIDTH=5, both modes, random out_ready -> every product matches the reference model and latency equals WIDTH every time.
